// File: rtl/i2c_cfg_arbiter.sv
// Round-robin arbiter sharing one I2C write master among N_REQ register-config requesters.
// Define I2C_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC en-cycles and flag s_err.
module i2c_cfg_arbiter #(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [N_REQ*7-1:0]  s_addr,
  input  logic [N_REQ*16-1:0] s_wdata,
  input  logic [N_REQ-1:0]   s_req,
  output logic [N_REQ-1:0]   s_ack,
  output logic [N_REQ-1:0]   s_err,
  output logic [6:0]         m_addr,
  output logic [15:0]        m_wdata,
  output logic               m_req,
  input  logic               m_ack,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] pending, pending_nxt;
  logic [N_REQ-1:0] grant_nxt, s_ack_nxt, done_mask;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   pick;
  logic [6:0]       m_addr_nxt;
  logic [15:0]      m_wdata_nxt;
  logic             m_req_nxt;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [N_REQ-1:0] s_err_q, s_err_nxt;
  logic             expired;
  assign expired = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign s_err   = s_err_q;
`else
  assign s_err = '0;
`endif

  assign busy = (state != IDLE);

  // Returns {found, index}: first pending requester after `last`, wrapping modulo N_REQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] pend,
                                              input logic [IDX_W-1:0] last);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   c;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = {1'b0, last} + (IDX_W + 1)'(k);
      if (c >= (IDX_W + 1)'(N_REQ)) c = c - (IDX_W + 1)'(N_REQ);
      if (!found && pend[c[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_nxt      = state;
    pending_nxt    = pending;
    grant_nxt      = grant;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    m_addr_nxt     = m_addr;
    m_wdata_nxt    = m_wdata;
    m_req_nxt      = m_req;
    s_ack_nxt      = s_ack;
    done_mask      = '0;
`ifdef I2C_ARB_TIMEOUT_EN
    tmo_cnt_nxt    = tmo_cnt;
    s_err_nxt      = s_err_q;
`endif
    pick     = rr_pick(pending, last_grant);
    pick_idx = pick[IDX_W-1:0];
    if (en) begin
      case (state)
        IDLE: begin
          if (pick[IDX_W]) begin
            grant_nxt   = N_REQ'(1) << pick_idx;
            owner_nxt   = pick_idx;
            m_addr_nxt  = s_addr[7*pick_idx +: 7];
            m_wdata_nxt = s_wdata[16*pick_idx +: 16];
            m_req_nxt   = 1'b1;
            state_nxt   = ISSUE;
          end
        end
        ISSUE: begin
          m_req_nxt = 1'b0;
          state_nxt = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          tmo_cnt_nxt = '0;
`endif
        end
        WAIT: begin
          // m_ack wins over a simultaneous timeout expiry
          if (m_ack) begin
            done_mask      = grant;
            s_ack_nxt      = grant;
            last_grant_nxt = owner;
            state_nxt      = DONE;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (expired) begin
            done_mask      = grant;
            s_ack_nxt      = grant;
            s_err_nxt      = grant;
            last_grant_nxt = owner;
            state_nxt      = DONE;
          end else begin
            tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          s_ack_nxt = '0;
          grant_nxt = '0;
          state_nxt = IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
          s_err_nxt = '0;
`endif
        end
        default: state_nxt = IDLE;
      endcase
      // A new request in the completion cycle keeps the requester pending
      pending_nxt = (pending & ~done_mask) | s_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      owner      <= '0;
      grant      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_req      <= 1'b0;
      s_ack      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      s_err_q    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      grant      <= grant_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      m_req      <= m_req_nxt;
      s_ack      <= s_ack_nxt;
`ifdef I2C_ARB_TIMEOUT_EN
      tmo_cnt    <= tmo_cnt_nxt;
      s_err_q    <= s_err_nxt;
`endif
    end
  end

endmodule

// File: doc/i2c_cfg_arbiter.md
Name: i2c_cfg_arbiter

Overview:
- Shares one I2C write master between N_REQ register-configuration requesters, e.g. the WM8731 codec init sequencer, the FM tuner config FSM and runtime volume control.
- Each requester uses the addr/wdata/req/ack write protocol unchanged.
- The arbiter queues request pulses, grants round-robin, forwards one transaction at a time downstream and routes the ack back to the owner.
- All sequencing advances only on the shared clock-enable `en`.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYC, 4096, `en`-cycles to wait for m_ack before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  One clock; reset is synchronous and active-low.
- en  in  1  clock enable; state and pending updates occur only when en=1.
- s_addr  in  N_REQ*7  per-requester 7-bit I2C device address; slice i is bits [7i+6:7i].
- s_wdata  in  N_REQ*16  per-requester write data {reg byte, data byte}; slice i is bits [16i+15:16i].
- s_req  in  N_REQ  request pulse, one `en`-cycle wide; addr/wdata are held stable until ack.
- s_ack  out  N_REQ  transaction-complete, one-hot.
- s_err  out  N_REQ  transaction aborted; valid with s_ack.
- m_addr  out  7  device address to I2C master.
- m_wdata  out  16  data to I2C master.
- m_req  out  1  request to I2C master.
- m_ack  in  1  completion from I2C master.
- grant  out  N_REQ  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (reset_n=0 at clk edge, regardless of en):
  - State=IDLE.
  - pending=0, last_grant=N_REQ-1.
  - All outputs 0: m_addr, m_wdata, m_req, s_ack, s_err, grant, busy.
- pending[i]:
  - Set on en & s_req[i].
  - Cleared when requester i receives s_ack.
  - If set and clear coincide, set wins.
  - A req while pending[i]=1 is absorbed, not queued twice.
- State IDLE (en=1, pending≠0):
  - Select the first pending index searching upward from last_grant+1, wrapping modulo N_REQ.
  - Register grant and capture that requester's addr/wdata into m_addr/m_wdata.
  - Go to ISSUE.
- State ISSUE:
  - m_req=1 for exactly this one `en`-cycle; m_addr/m_wdata remain stable.
  - Go to WAIT on the next en.
- State WAIT:
  - m_req=0; m_addr/m_wdata held.
  - On en & m_ack: clear pending[grant], last_grant=grant, go to DONE.
  - m_ack outside WAIT is ignored.
- State DONE:
  - s_ack[grant]=1 (and s_err[grant] if aborted) for exactly one `en`-cycle, i.e. registered high from the DONE entry edge until the next en edge.
  - Then grant=0, go to IDLE.
- Latency:
  - Idle request seen at en-cycle k.
  - Grant at k+1; m_req at k+1..k+2 (ISSUE).
  - m_ack at cycle j gives s_ack at j+1.
  - Minimum request-to-ack is 4 `en`-cycles.
- Back-to-back: IDLE re-arbitrates on the en-cycle after DONE; there are no idle bubbles beyond that one.
- Fairness: with all requesters pending continuously, grants rotate 0,1,2,0,…; no requester waits more than N_REQ-1 transactions.
- en=0: all registers hold, including s_ack/m_req levels.
- Reset mid-transaction: abandons the transfer; no s_ack is produced; requesters must re-issue.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT entry and increments each en-cycle in WAIT.
  - At TIMEOUT_CYC without m_ack, go to DONE with s_err[grant]=1 alongside s_ack[grant].
  - pending and last_grant update exactly as on a normal completion.
  - m_ack arriving in the same cycle as expiry takes precedence (s_err=0).
- Undefined:
  - No counter; WAIT holds indefinitely.
  - s_err is tied to 0.

Test Plan:
- Single request: en=1 every cycle, s_req[1] pulse with addr=0x1A, wdata=0x0C67; m_ack 5 cycles after m_req → m_addr=0x1A, m_wdata=0x0C67, one m_req pulse, grant=3'b010, s_ack=3'b010 for one cycle, s_err=0.
- Simultaneous: s_req=3'b111 in one cycle → m_req issued for requesters 0,1,2 in that order, each with its own data; three s_ack pulses, one-hot, in the same order.
- Round-robin fairness: requester 0 re-requests immediately after each ack while 2 is pending → grant sequence 0,2,0,2; requester 2 is never starved.
- Clock enable: en high 1 in 4 cycles → all states, m_req and s_ack widths span exactly one en period (4 clk); same sequence as with en=1.
- Reset mid-WAIT: reset_n=0 for one clk during WAIT → next cycle busy=0, grant=0, pending=0; a later m_ack causes no s_ack.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): m_ack never asserted → s_ack and s_err for the owner exactly 16 en-cycles after WAIT entry; next pending requester is granted.
